// File: rtl/bridge_pkg.sv
// Shared definitions for the drawbridge lift controller: state encoding,
// road-light codes and small output-decode helpers.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WARN  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RAISE = 3'd3,
    ST_OPEN  = 3'd4,
    ST_LOWER = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  localparam logic [1:0] TFL_GREEN  = 2'b00;
  localparam logic [1:0] TFL_YELLOW = 2'b01;
  localparam logic [1:0] TFL_RED    = 2'b10;

  // Road light shown while in a given state; unknown codes fail safe to red.
  function automatic logic [1:0] tfl_of(input state_t s);
    logic [1:0] t;
    case (s)
      ST_IDLE: t = TFL_GREEN;
      ST_WARN: t = TFL_YELLOW;
      default: t = TFL_RED;
    endcase
    return t;
  endfunction

  // Alarm sounds whenever the road is being closed, the deck moves, or a fault is latched.
  function automatic logic alarm_of(input state_t s);
    logic a;
    case (s)
      ST_IDLE: a = 1'b0;
      ST_OPEN: a = 1'b0;
      default: a = 1'b1;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/bridge_timer.sv
// Shared phase timer: CW-bit saturating up-counter with synchronous clear
// and an equality flag against a caller-selected compare value.
module bridge_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] cmp_val,
  output logic          hit
);

  logic [CW-1:0] cnt;

  // Count up each cycle, restart on clear, hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CW{1'b0}};
    end else if (clr) begin
      cnt <= {CW{1'b0}};
    end else if (cnt != {CW{1'b1}}) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign hit = (cnt == cmp_val);

endmodule

// File: rtl/bridge_lift_ctrl.sv
// Drawbridge lift controller: sequences road lights, alarm and deck motor
// around ship passages with N deck lanes, timed warn/hold phases, late-ship
// re-raise and a latched fault with operator clear.
// Optional motor watchdog compiled in with macro BRIDGE_WATCHDOG_EN.
module bridge_lift_ctrl
  import bridge_pkg::*;
#(
  parameter int N_LANES  = 2,
  parameter int WARN_CYC = 16,
  parameter int HOLD_CYC = 32,
  parameter int MOTOR_TO = 256
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               SHIP_IN,
  input  logic               SHIP_OUT,
  input  logic [N_LANES-1:0] DECK,
  input  logic               LIM_UP,
  input  logic               LIM_DN,
  input  logic               CLR_FAULT,
  output logic               MT_UP,
  output logic               MT_DN,
  output logic               AL,
  output logic [1:0]         TFL,
  output logic               FAULT,
  output logic [2:0]         STATE
);

  localparam int MAX_WH = (WARN_CYC > HOLD_CYC) ? WARN_CYC : HOLD_CYC;
  localparam int MAX_ALL = (MAX_WH > MOTOR_TO) ? MAX_WH : MOTOR_TO;
  localparam int CW = $clog2(MAX_ALL + 1);

  state_t        state;
  state_t        state_next;
  logic          gone;
  logic          gone_next;
  logic          clr;
  logic          hit;
  logic [CW-1:0] cmp_val;

  bridge_timer #(.CW(CW)) u_timer (
    .clk     (Clock),
    .rst     (Reset),
    .clr     (clr),
    .cmp_val (cmp_val),
    .hit     (hit)
  );

  // Pick the timer compare value that matters in the current state.
  always_comb begin
    cmp_val = {CW{1'b1}};
    case (state)
      ST_WARN:  cmp_val = CW'(WARN_CYC - 1);
      ST_OPEN:  cmp_val = CW'(HOLD_CYC - 1);
      ST_RAISE: cmp_val = CW'(MOTOR_TO - 1);
      ST_LOWER: cmp_val = CW'(MOTOR_TO - 1);
      default:  cmp_val = {CW{1'b1}};
    endcase
  end

  // Next-state logic; a dual-limit reading overrides everything but reset.
  always_comb begin
    state_next = state;
    if (LIM_UP && LIM_DN) begin
      state_next = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (SHIP_IN) state_next = ST_WARN;
          else         state_next = ST_IDLE;
        end
        ST_WARN: begin
          if (hit) state_next = ST_CLEAR;
          else     state_next = ST_WARN;
        end
        ST_CLEAR: begin
          if (DECK == {N_LANES{1'b0}}) state_next = ST_RAISE;
          else                         state_next = ST_CLEAR;
        end
        ST_RAISE: begin
          if (LIM_UP) state_next = ST_OPEN;
`ifdef BRIDGE_WATCHDOG_EN
          else if (hit) state_next = ST_FAULT;
`endif
          else state_next = ST_RAISE;
        end
        ST_OPEN: begin
          // Any ship activity this cycle restarts the hold, so it cannot end now.
          if (gone && hit && !SHIP_IN && !SHIP_OUT) state_next = ST_LOWER;
          else                                      state_next = ST_OPEN;
        end
        ST_LOWER: begin
          if (SHIP_IN)     state_next = ST_RAISE;
          else if (LIM_DN) state_next = ST_IDLE;
`ifdef BRIDGE_WATCHDOG_EN
          else if (hit)    state_next = ST_FAULT;
`endif
          else state_next = ST_LOWER;
        end
        ST_FAULT: begin
          if (CLR_FAULT && LIM_DN && !LIM_UP) state_next = ST_IDLE;
          else if (CLR_FAULT && !LIM_DN)      state_next = ST_LOWER;
          else                                state_next = ST_FAULT;
        end
        default: state_next = ST_FAULT;
      endcase
    end
  end

  // Ship-gone flag and timer restart; the hold timer restarts on any ship sensor activity.
  always_comb begin
    gone_next = 1'b0;
    if (state == ST_OPEN && state_next == ST_OPEN) begin
      if (SHIP_IN)       gone_next = 1'b0;
      else if (SHIP_OUT) gone_next = 1'b1;
      else               gone_next = gone;
    end else begin
      gone_next = 1'b0;
    end
    clr = (state_next != state) || ((state == ST_OPEN) && (SHIP_IN || SHIP_OUT));
  end

  // State register plus registered Moore outputs decoded from the next state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      gone  <= 1'b0;
      MT_UP <= 1'b0;
      MT_DN <= 1'b0;
      AL    <= 1'b0;
      TFL   <= TFL_GREEN;
      FAULT <= 1'b0;
      STATE <= 3'd0;
    end else begin
      state <= state_next;
      gone  <= gone_next;
      MT_UP <= (state_next == ST_RAISE);
      MT_DN <= (state_next == ST_LOWER);
      AL    <= alarm_of(state_next);
      TFL   <= tfl_of(state_next);
      FAULT <= (state_next == ST_FAULT);
      STATE <= state_next;
    end
  end

endmodule

// File: doc/bridge_lift_ctrl.md
# bridge_lift_ctrl

Parametrised drawbridge controller, successor to the fixed six-sensor `state_flat` FSM. It sequences road traffic lights, warning alarm and deck motor around ship passages, and adds:
- N deck-occupancy lanes
- timed warning and hold phases
- re-raise on a late ship
- a latched fault state with operator clear

It sits between the raw sensor/limit-switch inputs and the motor/light drivers of the bridge top level.

## Interface
- N_LANES, 2: number of deck vehicle-presence sensors (≥1)
- WARN_CYC, 16: cycles of yellow light plus alarm before road closes (≥1)
- HOLD_CYC, 32: cycles the bridge stays open after the ship clears (≥1)
- MOTOR_TO, 256: motor watchdog limit in cycles (used only with watchdog compiled in)
- CW, derived: counter width, $clog2 of max(WARN_CYC, HOLD_CYC, MOTOR_TO)+1

- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- SHIP_IN  in  1  ship-approaching sensor
- SHIP_OUT  in  1  ship-cleared sensor
- DECK  in  N_LANES  vehicle present per lane
- LIM_UP  in  1  deck fully raised
- LIM_DN  in  1  deck fully lowered
- CLR_FAULT  in  1  operator fault acknowledge
- MT_UP  out  1  raise motor
- MT_DN  out  1  lower motor
- AL  out  1  audible alarm
- TFL  out  2  road light: 00 green, 01 yellow, 10 red
- FAULT  out  1  fault latched
- STATE  out  3  current state code, for debug

## Operation
All outputs are decoded from the state register only (Moore). One shared counter `cnt` clears on every state entry and increments each cycle otherwise.

The state machine, with outputs per state:
- IDLE: TFL=00, motors off, AL=0.
  - SHIP_IN=1 → WARN.
- WARN: TFL=01, AL=1.
  - cnt==WARN_CYC-1 → CLEAR.
- CLEAR: TFL=10, AL=1.
  - DECK==0 → RAISE; otherwise wait indefinitely.
- RAISE: MT_UP=1, TFL=10, AL=1.
  - LIM_UP=1 → OPEN.
- OPEN: motors off, TFL=10, AL=0.
  - An internal flag `gone` sets on SHIP_OUT=1.
  - `gone` clears, and cnt restarts, whenever SHIP_IN=1.
  - gone=1 and cnt==HOLD_CYC-1 → LOWER.
- LOWER: MT_DN=1, TFL=10, AL=1.
  - LIM_DN=1 → IDLE.
  - SHIP_IN=1 → RAISE (re-raise); this has priority over LIM_DN.
- FAULT: motors off, TFL=10, AL=1, FAULT=1.
  - CLR_FAULT=1 with LIM_DN=1 and LIM_UP=0 → IDLE.
  - CLR_FAULT=1 with the bridge not down → LOWER.

Boundary conditions:
- LIM_UP=1 and LIM_DN=1 together, in any state → FAULT. This has highest priority after Reset.
- MT_UP and MT_DN are never 1 in the same cycle.
- Reset mid-motion: motors off, and all outputs return to reset values, on the same edge.
- Reset values: state IDLE, cnt 0, gone 0, MT_UP 0, MT_DN 0, AL 0, TFL 00, FAULT 0, STATE 0.
- cnt saturates at its maximum value; it never wraps.

## Timing
- Inputs are sampled on the rising edge. The new state and outputs are visible right after that same edge: 1-cycle latency from input to output.
- WARN lasts exactly WARN_CYC cycles.
- The OPEN hold lasts exactly HOLD_CYC cycles after the last cycle in which SHIP_OUT=1 or SHIP_IN=1.
- Inputs are synchronised externally; the block adds no synchronisers.

## Configuration
- BRIDGE_WATCHDOG_EN defined: in RAISE or LOWER, if cnt==MOTOR_TO-1 is reached without the expected limit switch → FAULT.
- BRIDGE_WATCHDOG_EN not defined: no timeout logic. FAULT is reachable only through the dual-limit condition, and MOTOR_TO is ignored.

## Structure
- Package `bridge_pkg` holds:
  - the state encoding: IDLE 0, WARN 1, CLEAR 2, RAISE 3, OPEN 4, LOWER 5, FAULT 6
  - TFL codes: TFL_GREEN, TFL_YELLOW, TFL_RED
- Sub-module `bridge_timer`: CW-bit saturating counter with synchronous clear and an equality-compare flag. It is instantiated once; the FSM selects the compare value per state.

## Test plan
- Nominal cycle, with WARN_CYC=4 and HOLD_CYC=3:
  - Stimulus: SHIP_IN pulse; LIM_UP 5 cycles into RAISE; SHIP_OUT pulse; LIM_DN 5 cycles into LOWER.
  - Response: TFL goes 00→01 for exactly 4 cycles → 10. MT_UP high until LIM_UP. OPEN lasts 3 cycles after SHIP_OUT. MT_DN high until LIM_DN. Then IDLE with TFL=00.
- Occupied deck: DECK=2'b01 at WARN expiry → stays in CLEAR with TFL=10 and MT_UP=0. DECK→0 → RAISE on the next edge.
- Late ship: SHIP_IN=1 on the 2nd cycle of LOWER → MT_DN drops and MT_UP rises on the next edge.
- Dual limit: LIM_UP=LIM_DN=1 during OPEN → FAULT=1, AL=1, motors 0.
  - CLR_FAULT with LIM_DN=0 → LOWER.
  - CLR_FAULT with LIM_DN=1 and LIM_UP=0 → IDLE.
- Watchdog, with BRIDGE_WATCHDOG_EN and MOTOR_TO=8: no LIM_UP in RAISE → FAULT after exactly 8 cycles. Without the macro, still in RAISE after 100 cycles.
- Reset asserted during RAISE → MT_UP=0, TFL=00, STATE=0 immediately after that edge.
